// File: rtl/uart_param_core_if.sv
// User-side bundle of the UART core: the TX request/handshake and the RX
// result strobe. Serial pins stay outside this bundle.
//   start        TX request, honoured only while o_tx_busy is low
//   tx_data      TX payload, captured on the accepted start cycle
//   o_tx_busy    TX frame in flight
//   o_tx_done    1-cycle pulse at the end of the last stop bit
//   rx_data      last received payload
//   o_rx_done    1-cycle pulse when rx_data and the error flags update
//   o_parity_err parity mismatch of the last received frame
//   o_frame_err  stop bit sampled low in the last received frame
// master = user logic, slave = UART core.
interface uart_param_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 o_tx_busy;
  logic                 o_tx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 o_rx_done;
  logic                 o_parity_err;
  logic                 o_frame_err;

  modport master (
    output start, tx_data,
    input  o_tx_busy, o_tx_done, rx_data, o_rx_done, o_parity_err, o_frame_err
  );

  modport slave (
    input  start, tx_data,
    output o_tx_busy, o_tx_done, rx_data, o_rx_done, o_parity_err, o_frame_err
  );
endinterface

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART core: configurable data width (LSB first),
// none/even/odd parity, 1 or 2 stop bits, and a 16x-style oversampled
// receiver with false-start rejection and parity/frame error flags.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    user-side handshake bundle (slave side)
//   o_txd  serial TX line, idle high
//   rx     serial RX line, asynchronous to clk
module uart_param_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  uart_param_core_if.slave  bus,
  output logic              o_txd,
  input  logic              rx
);

  localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TXC_W    = $clog2(BIT_CLKS);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int IDX_W    = 3;

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            tx_state;
  logic [TXC_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_txd;
  logic                 tx_busy;
  logic                 tx_done;

  // The TX bit timer is a private clock counter restarted on accept, so every
  // bit lasts exactly DIV*OVERSAMPLE clocks regardless of the RX tick phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_txd   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE) begin
        tx_txd <= 1'b1;
        if (bus.start) begin
          tx_shreg <= bus.tx_data;
          tx_par   <= (PARITY == 2) ? ~^bus.tx_data : ^bus.tx_data;
          tx_cnt   <= '0;
          tx_idx   <= '0;
          tx_txd   <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= TX_START;
        end
      end else if (tx_cnt == TXC_W'(BIT_CLKS - 1)) begin
        tx_cnt <= '0;
        case (tx_state)
          TX_START: begin
            tx_txd   <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_idx == IDX_W'(DATA_BITS - 1)) begin
              tx_idx <= '0;
              if (PARITY != 0) begin
                tx_txd   <= tx_par;
                tx_state <= TX_PAR;
              end else begin
                tx_txd   <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_txd   <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
            end
          end
          TX_PAR: begin
            tx_txd   <= 1'b1;
            tx_idx   <= '0;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_idx == IDX_W'(STOP_BITS - 1)) begin
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  assign o_txd         = tx_txd;
  assign bus.o_tx_busy = tx_busy;
  assign bus.o_tx_done = tx_done;

  // ------------------------------------------------------- RX tick gen
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  rx_state_t            rx_state;
  logic                 rx_s1, rx_s2;
  logic [OS_W-1:0]      rx_os;
  logic [IDX_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par_acc;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done;
  logic                 rx_perr;
  logic                 rx_ferr;

  // rx_par_acc is the XOR of all data bits plus the received parity bit:
  // 0 is a good frame for even parity, 1 for odd.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_os      <= '0;
      rx_idx     <= '0;
      rx_shreg   <= '0;
      rx_par_acc <= 1'b0;
      rx_data_q  <= '0;
      rx_done    <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_done <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (!rx_s2) begin
          rx_os    <= '0;
          rx_state <= RX_START;
        end
      end else if (tick) begin
        case (rx_state)
          RX_START: begin
            // Half a bit in: still low means a real start bit, else a glitch.
            if (rx_os == OS_W'(OVERSAMPLE / 2 - 1)) begin
              rx_os      <= '0;
              rx_idx     <= '0;
              rx_par_acc <= 1'b0;
              rx_state   <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_os == OS_W'(OVERSAMPLE - 1)) begin
              rx_os      <= '0;
              rx_shreg   <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
              rx_par_acc <= rx_par_acc ^ rx_s2;
              if (rx_idx == IDX_W'(DATA_BITS - 1))
                rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
              else
                rx_idx <= rx_idx + 1'b1;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          RX_PAR: begin
            if (rx_os == OS_W'(OVERSAMPLE - 1)) begin
              rx_os      <= '0;
              rx_par_acc <= rx_par_acc ^ rx_s2;
              rx_state   <= RX_STOP;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          RX_STOP: begin
            // Results land at the stop-bit centre; leaving straight away
            // leaves half a bit of slack for a back-to-back start edge.
            if (rx_os == OS_W'(OVERSAMPLE - 1)) begin
              rx_os     <= '0;
              rx_data_q <= rx_shreg;
              rx_perr   <= (PARITY == 1) ? rx_par_acc :
                           (PARITY == 2) ? ~rx_par_acc : 1'b0;
              rx_ferr   <= ~rx_s2;
              rx_done   <= 1'b1;
              rx_state  <= RX_IDLE;
            end else begin
              rx_os <= rx_os + 1'b1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.o_rx_done    = rx_done;
  assign bus.o_parity_err = rx_perr;
  assign bus.o_frame_err  = rx_ferr;

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three instances at 32 clk/bit.
//   a: 8N1, TX looped to RX (or RX driven by the bench when sel_a=1)
//   b: 7 data, even parity, 2 stop, TX looped to RX
//   c: 8 data, odd parity, 1 stop, RX driven by the bench
// Stimulus pushes expected results into queues; one negedge monitor pops
// and compares whenever a DUT strobes, plus queued point checks.
module tb_uart_param_core;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 3_125_000;
  localparam int OS       = 16;
  localparam int BITC     = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  uart_param_core_if #(.DATA_BITS(8)) if_a();
  uart_param_core_if #(.DATA_BITS(7)) if_b();
  uart_param_core_if #(.DATA_BITS(8)) if_c();

  logic txd_a, txd_b, txd_c;
  logic drv_a = 1'b1, drv_c = 1'b1, sel_a = 1'b0;
  logic rx_a, rx_b, rx_c;
  assign rx_a = sel_a ? drv_a : txd_a;
  assign rx_b = txd_b;
  assign rx_c = drv_c;

  uart_param_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a), .o_txd(txd_a), .rx(rx_a));
  uart_param_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset), .bus(if_b), .o_txd(txd_b), .rx(rx_b));
  uart_param_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .bus(if_c), .o_txd(txd_c), .rx(rx_c));

  typedef struct { logic [7:0] data; logic perr; logic ferr; } rx_exp_t;
  typedef struct { string name; int inst; logic [13:0] exp; logic [13:0] mask; logic force_fail; } pt_t;

  rx_exp_t rx_q[3][$];
  int      done_q[2][$];
  pt_t     pt_q[$];

  // Snapshot layout: [13]txd [12]busy [11]tx_done [10]rx_done [9]perr [8]ferr [7:0]rx_data
  function automatic logic [13:0] snap(int inst);
    case (inst)
      0: return {txd_a, if_a.o_tx_busy, if_a.o_tx_done, if_a.o_rx_done,
                 if_a.o_parity_err, if_a.o_frame_err, if_a.rx_data};
      1: return {txd_b, if_b.o_tx_busy, if_b.o_tx_done, if_b.o_rx_done,
                 if_b.o_parity_err, if_b.o_frame_err, 1'b0, if_b.rx_data};
      default: return {txd_c, if_c.o_tx_busy, if_c.o_tx_done, if_c.o_rx_done,
                 if_c.o_parity_err, if_c.o_frame_err, if_c.rx_data};
    endcase
  endfunction

  // Frame length in clocks straight from the frame format.
  function automatic int frame_clks(int db, int par, int stop);
    return (1 + db + ((par != 0) ? 1 : 0) + stop) * BITC;
  endfunction

  // ------------------------------------------------------------ monitor
  logic [13:0] mon_s;
  rx_exp_t     mon_e;
  pt_t         mon_p;
  int          mon_w;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mon_s = snap(i);
      if (mon_s[10]) begin
        checks++;
        if (rx_q[i].size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected inst%0d got data=%h perr=%b ferr=%b (no frame expected)",
                   i, mon_s[7:0], mon_s[9], mon_s[8]);
        end else begin
          mon_e = rx_q[i].pop_front();
          if ({mon_s[7:0], mon_s[9], mon_s[8]} !== {mon_e.data, mon_e.perr, mon_e.ferr}) begin
            errors++;
            $display("FAIL rx_frame inst%0d got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                     i, mon_s[7:0], mon_s[9], mon_s[8], mon_e.data, mon_e.perr, mon_e.ferr);
          end
        end
      end
      if (i < 2 && mon_s[11]) begin
        checks++;
        if (done_q[i].size() == 0) begin
          errors++;
          $display("FAIL tx_done_unexpected inst%0d at cycle %0d", i, cyc);
        end else begin
          mon_w = done_q[i].pop_front();
          if (cyc != mon_w) begin
            errors++;
            $display("FAIL tx_done_latency inst%0d got cycle %0d want cycle %0d", i, cyc, mon_w);
          end
        end
      end
    end
    while (pt_q.size() > 0) begin
      mon_p = pt_q.pop_front();
      mon_s = snap(mon_p.inst);
      checks++;
      if (mon_p.force_fail || ((mon_s & mon_p.mask) !== (mon_p.exp & mon_p.mask))) begin
        errors++;
        $display("FAIL %s inst%0d got %b want %b mask %b", mon_p.name, mon_p.inst,
                 mon_s, mon_p.exp, mon_p.mask);
      end
    end
  end

  // ---------------------------------------------------------- stimulus
  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pt(string n, int inst, logic [13:0] e, logic [13:0] m, logic ff);
    pt_t p;
    p.name = n; p.inst = inst; p.exp = e; p.mask = m; p.force_fail = ff;
    pt_q.push_back(p);
  endtask

  task automatic wait_idle(int inst);
    int n;
    logic [13:0] s;
    n = 0;
    s = snap(inst);
    while (s[12] && n < 2000) begin
      tick1();
      n++;
      s = snap(inst);
    end
    if (n >= 2000) push_pt("tx_idle_timeout", inst, '0, '0, 1'b1);
  endtask

  // Loopback send on instance a (0) or b (1): expect the payload back with no
  // errors and tx_done exactly one frame after the accepting edge.
  task automatic send(int inst, logic [7:0] d);
    rx_exp_t e;
    wait_idle(inst);
    e.data = (inst == 1) ? (d & 8'h7F) : d;
    e.perr = 1'b0;
    e.ferr = 1'b0;
    if (inst == 0) begin
      if_a.start = 1'b1; if_a.tx_data = d;
      done_q[0].push_back(cyc + 1 + frame_clks(8, 0, 1));
    end else begin
      if_b.start = 1'b1; if_b.tx_data = d[6:0];
      done_q[1].push_back(cyc + 1 + frame_clks(7, 1, 2));
    end
    rx_q[inst].push_back(e);
    tick1();
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  task automatic set_rx(int inst, logic b);
    if (inst == 0) drv_a = b;
    else           drv_c = b;
  endtask

  // Bench-built serial frame. A bad stop bit is held low only past its
  // centre, then the line returns high.
  task automatic drive_frame(int inst, logic [7:0] d, int db, int par, logic bad_par, logic stop_ok);
    logic    bits[$];
    logic [7:0] dm;
    logic    p;
    int      ones;
    rx_exp_t e;
    dm   = d & 8'((1 << db) - 1);
    ones = $countones(dm);
    p    = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    p    = p ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) bits.push_back(dm[i]);
    if (par != 0) bits.push_back(p);
    e.data = dm;
    e.perr = (par != 0) && bad_par;
    e.ferr = !stop_ok;
    rx_q[inst].push_back(e);
    foreach (bits[i]) begin
      set_rx(inst, bits[i]);
      repeat (BITC) tick1();
    end
    set_rx(inst, stop_ok);
    repeat (stop_ok ? BITC : 24) tick1();
    set_rx(inst, 1'b1);
    repeat (BITC) tick1();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int left;
    if_a.start = 1'b0; if_a.tx_data = '0;
    if_b.start = 1'b0; if_b.tx_data = '0;
    if_c.start = 1'b0; if_c.tx_data = '0;
    reset = 1'b0;
    repeat (5) tick1();
    for (int i = 0; i < 3; i++) push_pt("reset_state", i, 14'h2000, 14'h3FFF, 1'b0);
    tick1();
    reset = 1'b1;
    tick1();

    // 8N1 loopback: directed then random, back-to-back on tx_done
    send(0, 8'h01);
    send(0, 8'hAA);
    repeat (6) send(0, 8'($urandom_range(0, 255)));

    // 7E2 loopback
    send(1, 8'h55);
    repeat (4) send(1, 8'($urandom_range(0, 127)));
    wait_idle(0);
    wait_idle(1);
    repeat (64) tick1();

    // odd parity, bench-driven: bad parity, then good, then random mix
    drive_frame(2, 8'hA5, 8, 2, 1'b1, 1'b1);
    drive_frame(2, 8'hA5, 8, 2, 1'b0, 1'b1);
    repeat (6) drive_frame(2, 8'($urandom_range(0, 255)), 8, 2,
                           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));

    // 8N1 bench-driven: frame error, short glitch, then a clean frame
    sel_a = 1'b1;
    drv_a = 1'b1;
    repeat (4) tick1();
    drive_frame(0, 8'h3C, 8, 0, 1'b0, 1'b0);
    drv_a = 1'b0;
    repeat (4) tick1();
    drv_a = 1'b1;
    repeat (100) tick1();
    drive_frame(0, 8'h81, 8, 0, 1'b0, 1'b1);
    sel_a = 1'b0;
    repeat (8) tick1();

    // start while busy is ignored; reset mid-frame aborts without done pulses
    wait_idle(0);
    acc = cyc + 1;
    if_a.start = 1'b1; if_a.tx_data = 8'h12;
    tick1();
    if_a.start = 1'b0;
    while (cyc < acc + 99) tick1();
    if_a.start = 1'b1; if_a.tx_data = 8'h34;
    tick1();
    if_a.start = 1'b0;
    while (cyc < acc + 110) tick1();
    // bit 3 of the frame = data bit 2: 0 for 0x12, 1 for 0x34
    push_pt("ignored_start", 0, 14'h1000, 14'h3000, 1'b0);
    while (cyc < acc + 149) tick1();
    reset = 1'b0;
    tick1();
    for (int i = 0; i < 3; i++) push_pt("reset_abort", i, 14'h2000, 14'h3FFF, 1'b0);
    tick1();
    tick1();
    reset = 1'b1;
    repeat (400) tick1();

    left = rx_q[0].size() + rx_q[1].size() + rx_q[2].size() + done_q[0].size() + done_q[1].size();
    push_pt("missing_outputs", 0, '0, '0, left != 0);
    tick1();
    tick1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
